clk_div_prog: RTL and testbench
===============================

# clk_div_prog

Multi-channel, runtime-programmable clock divider and tick generator. Each of `CH` channels divides `clk` by an integer period loaded at runtime and produces a registered, glitch-free divided clock and a one-cycle period-end tick. Divisor changes are staged and applied only at a period boundary, and a global sync phase-aligns all channels. It sits between the system clock and slow peripherals such as LED blinkers, UART baud generators and scan timers, replacing per-use fixed power-of-two dividers.

## Interface
- `CH`, default 4: number of channels, ≥1.
- `WIDTH`, default 16: divisor and counter width in bits.
- `DIV_RST`, default 0: divisor loaded into every channel at reset; 0 means disabled.
- `CHW`, default `$clog2(CH)` (minimum 1): channel-select width.

Ports:
- `clk` input 1: single clock; all logic on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `wr_en` input 1: divisor write strobe.
- `wr_ch` input CHW: target channel. Writes with `wr_ch ≥ CH` are ignored.
- `wr_div` input WIDTH: new period P in `clk` cycles. 0 disables the channel.
- `sync` input 1: restart all channels at phase 0.
- `clk_out` output CH: divided clock per channel, registered.
- `tick` output CH: one-cycle pulse in the last cycle of each period, registered.
- `pend` output CH: staged divisor not yet applied.

## Operation
- **Per-channel state:** active period `P`, staged period `S`, counter `cnt` (WIDTH bits), and flags/outputs `pend`, `clk_out`, `tick`.
- **Counting:**
  - If P ≥ 1: `cnt` runs 0,1,…,P-1 and then wraps to 0.
  - If P = 0: `cnt` is held at 0.
  - `cnt` never exceeds P-1. There is no overflow path, since P ≤ 2^WIDTH-1.
- **Output invariant:** after every edge, outputs match the new `cnt`/`P`:
  - `clk_out` = (P ≥ 2) && (cnt ≥ ceil(P/2)). Output is low for ceil(P/2) cycles, then high for floor(P/2) cycles. Odd P is low-biased by one cycle.
  - `tick` = (P ≥ 1) && (cnt == P-1).
- **Special periods:**
  - P = 1: `tick` is held 1 and `clk_out` is held 0.
  - P = 0: both outputs are held 0.
- **Write to an active channel (P ≥ 1):**
  - `S` ← `wr_div` and `pend` is set.
  - At the next wrap edge (`cnt` == P-1 → 0): P ← S, `pend` clears, and the new period starts at `cnt` = 0.
  - The current period always completes with the old P, so a write never produces a runt or glitch.
  - If the write edge is itself a wrap edge, `wr_div` is applied on that edge directly and `pend` never asserts.
- **Write to a disabled channel (P = 0):** applied on the write edge. P ← `wr_div`, `cnt` = 0, `pend` stays 0.
- **Back-to-back writes before a wrap:** the last write wins, and `pend` stays set.
- **Write of 0 to an active channel:** the channel stops at the next wrap. It is then held idle with outputs 0.
- **`sync`:** on that edge, every channel:
  - takes P ← S if `pend` is set;
  - takes `cnt` ← 0;
  - clears `pend`.

  A write in the same cycle as `sync` is applied, meaning `wr_div` is taken as the new P for the target channel. `sync` held high keeps all channels at `cnt` = 0.
- **Channel independence:** channels share only the write port and `sync`.

## Timing
- **Reset (`rst_n` low, asynchronous):**
  - every P = S = `DIV_RST`, `cnt` = 0;
  - `clk_out` = 0, `tick` = 0, `pend` = 0.

  After release, the first edge advances `cnt` to 1 (for P ≥ 2) and the outputs follow the invariant. If `DIV_RST` = 1, `tick` rises on the first edge.
- **Reset mid-period or with `pend` set:** the staged value is discarded and P returns to `DIV_RST`.
- **Write/sync latency:** inputs are sampled on edge t. `pend` is visible after edge t. An immediate apply shows its first new-period output state (`cnt` = 0) after edge t.
- **Tick spacing:** `tick` period is exactly P cycles in steady state. At a divisor change, the old period's tick is followed P_new cycles later by the first new tick.
- **Output paths:** all outputs come straight from flops. There is no combinational path from inputs to outputs.

## Test plan
- **Reset values:** CH=4, WIDTH=8, DIV_RST=0; reset, then 20 cycles → all `clk_out`, `tick`, `pend` = 0.
- **Basic periods:** write ch0 = 4 and ch1 = 5 (disabled → immediate).
  - ch0 `clk_out` pattern 0,0,1,1 repeating; `tick` every 4th cycle, coincident with the second high cycle.
  - ch1 `clk_out` pattern 0,0,0,1,1; `tick` every 5 cycles.
  - Check over 40 cycles.
- **Staged change:** ch0 running P = 6; at `cnt` = 2 write 3.
  - `pend` = 1 for 3 cycles.
  - Old period completes (tick at `cnt` = 5), then ticks every 3 cycles.
  - No `clk_out` pulse shorter than 1 new half-period.
- **Write on wrap, last-wins, stop:**
  - Write on the wrap edge → applied immediately, `pend` never 1.
  - Two writes (7 then 9) mid-period → P = 9 at wrap.
  - Write 0 → outputs 0 after wrap.
- **Sync:** ch0 = 4, ch1 = 8 at arbitrary phases; pulse `sync` → both `cnt` = 0 on the same edge. Their ticks coincide every 8 cycles thereafter. Repeat with a simultaneous write + `sync` → new P from that edge.
- **Edge cases:**
  - P = 1 → `tick` constant 1, `clk_out` 0.
  - P = 255 (WIDTH = 8) → tick spacing 255, with no wrap past 254.
  - Write to `wr_ch` = 4 with CH=4 → ignored.
  - Assert `rst_n` low mid-period with `pend` = 1 → outputs 0 immediately (asynchronously) and the staged value is dropped.

Source files
------------

// File: rtl/clk_div_prog_if.sv
// Write/sync port and per-channel outputs of the programmable clock divider.
interface clk_div_prog_if #(
  parameter int unsigned CH    = 4,
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHW   = (CH > 1) ? $clog2(CH) : 1
);
  logic             wr_en;
  logic [CHW-1:0]   wr_ch;
  logic [WIDTH-1:0] wr_div;
  logic             sync;
  logic [CH-1:0]    clk_out;
  logic [CH-1:0]    tick;
  logic [CH-1:0]    pend;

  modport master (
    output wr_en, wr_ch, wr_div, sync,
    input  clk_out, tick, pend
  );

  modport slave (
    input  wr_en, wr_ch, wr_div, sync,
    output clk_out, tick, pend
  );
endinterface

// File: rtl/clk_div_prog.sv
// Multi-channel runtime-programmable clock divider / tick generator.
// Divisor writes are staged to the period boundary; sync re-phases every channel.
module clk_div_prog #(
  parameter int unsigned CH      = 4,
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned DIV_RST = 0,
  parameter int unsigned CHW     = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  clk_div_prog_if.slave  bus
);

  localparam int unsigned W = WIDTH;

  logic [CH-1:0] clk_vec;
  logic [CH-1:0] tick_vec;
  logic [CH-1:0] pend_vec;

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [W-1:0] p_q, p_d;
    logic [W-1:0] s_q, s_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic         pend_q, pend_d;
    logic         clk_q, clk_d;
    logic         tick_q, tick_d;
    logic         hit;
    logic         wrap;

    // Next period/count; outputs are derived from the post-edge state so they stay registered.
    always_comb begin
      p_d    = p_q;
      s_d    = s_q;
      cnt_d  = cnt_q;
      pend_d = pend_q;
      hit    = bus.wr_en && (bus.wr_ch == CHW'(c));
      wrap   = (p_q != '0) && (cnt_q == p_q - W'(1));

      if (bus.sync) begin
        if (pend_q) p_d = s_q;
        if (hit) begin
          p_d = bus.wr_div;
          s_d = bus.wr_div;
        end
        cnt_d  = '0;
        pend_d = 1'b0;
      end else if (p_q == '0) begin
        if (hit) begin
          p_d   = bus.wr_div;
          s_d   = bus.wr_div;
          cnt_d = '0;
        end
      end else if (wrap) begin
        cnt_d  = '0;
        pend_d = 1'b0;
        if (hit) begin
          p_d = bus.wr_div;
          s_d = bus.wr_div;
        end else if (pend_q) begin
          p_d = s_q;
        end
      end else begin
        cnt_d = cnt_q + W'(1);
        if (hit) begin
          s_d    = bus.wr_div;
          pend_d = 1'b1;
        end
      end

      // Low for ceil(P/2) cycles, then high; odd periods lean low.
      clk_d  = (p_d >= W'(2)) && (cnt_d >= ((p_d >> 1) + W'(p_d[0])));
      tick_d = (p_d != '0) && (cnt_d == p_d - W'(1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        p_q    <= W'(DIV_RST);
        s_q    <= W'(DIV_RST);
        cnt_q  <= '0;
        pend_q <= 1'b0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        p_q    <= p_d;
        s_q    <= s_d;
        cnt_q  <= cnt_d;
        pend_q <= pend_d;
        clk_q  <= clk_d;
        tick_q <= tick_d;
      end
    end

    assign clk_vec[c]  = clk_q;
    assign tick_vec[c] = tick_q;
    assign pend_vec[c] = pend_q;
  end

  assign bus.clk_out = clk_vec;
  assign bus.tick    = tick_vec;
  assign bus.pend    = pend_vec;

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed self-checking bench for clk_div_prog (CH=4, WIDTH=8, DIV_RST=0, 3-bit channel select).
module tb_clk_div_prog;

  localparam int unsigned CH    = 4;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned CHW   = 3;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  clk_div_prog_if #(.CH(CH), .WIDTH(WIDTH), .CHW(CHW)) bus ();

  clk_div_prog #(.CH(CH), .WIDTH(WIDTH), .DIV_RST(0), .CHW(CHW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wr(input logic en, input logic [CHW-1:0] ch, input logic [WIDTH-1:0] div);
    bus.wr_en  = en;
    bus.wr_ch  = ch;
    bus.wr_div = div;
  endtask

  // Expected {pend, clk_out, tick} of ch0 across a 6 -> 3 staged change, starting at cnt=3.
  logic [2:0] staged_exp [9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    staged_exp = '{3'b110, 3'b110, 3'b111, 3'b000, 3'b000, 3'b011, 3'b000, 3'b000, 3'b011};
    rst_n = 1'b0;
    drive_wr(1'b0, '0, '0);
    bus.sync = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;

    // Reset state: everything idle with DIV_RST=0
    for (int k = 0; k < 20; k++) begin
      step();
      if (k == 0 || k == 19) begin
        check($sformatf("rst_clk%0d", k), 32'(bus.clk_out), 32'h0);
        check($sformatf("rst_tick%0d", k), 32'(bus.tick), 32'h0);
        check($sformatf("rst_pend%0d", k), 32'(bus.pend), 32'h0);
      end
    end

    // Basic periods: ch0=4, ch1=5, aligned with sync
    drive_wr(1'b1, 3'd0, 8'd4); step();
    drive_wr(1'b1, 3'd1, 8'd5); step();
    drive_wr(1'b0, '0, '0); bus.sync = 1'b1; step(); bus.sync = 1'b0;
    for (int k = 0; k < 40; k++) begin
      check($sformatf("b0clk%0d", k),  32'(bus.clk_out[0]), 32'((k % 4) >= 2));
      check($sformatf("b0tick%0d", k), 32'(bus.tick[0]),    32'((k % 4) == 3));
      check($sformatf("b1clk%0d", k),  32'(bus.clk_out[1]), 32'((k % 5) >= 3));
      check($sformatf("b1tick%0d", k), 32'(bus.tick[1]),    32'((k % 5) == 4));
      check($sformatf("bpend%0d", k),  32'(bus.pend),       32'h0);
      step();
    end

    // Staged change: ch0 P=6 via write+sync, then write 3 when cnt=2
    drive_wr(1'b1, 3'd0, 8'd6); bus.sync = 1'b1; step();
    drive_wr(1'b0, '0, '0); bus.sync = 1'b0;
    check("s_start", 32'({bus.pend[0], bus.clk_out[0], bus.tick[0]}), 32'h0);
    step(); step();
    drive_wr(1'b1, 3'd0, 8'd3); step();
    drive_wr(1'b0, '0, '0);
    for (int i = 0; i < 9; i++) begin
      check($sformatf("staged%0d", i), 32'({bus.pend[0], bus.clk_out[0], bus.tick[0]}),
            32'(staged_exp[i]));
      step();
    end

    // Write on the wrap edge applies immediately (ch0 P=3 at cnt=0 here)
    step(); step();
    check("wrap_pre_tick", 32'(bus.tick[0]), 32'h1);
    drive_wr(1'b1, 3'd0, 8'd5); step();
    drive_wr(1'b0, '0, '0);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("w5pend%0d", k), 32'(bus.pend[0]),    32'h0);
      check($sformatf("w5clk%0d", k),  32'(bus.clk_out[0]), 32'(k >= 3));
      check($sformatf("w5tick%0d", k), 32'(bus.tick[0]),    32'(k == 4));
      step();
    end

    // Last write wins: 7 then 9 mid-period
    step();
    drive_wr(1'b1, 3'd0, 8'd7); step();
    drive_wr(1'b1, 3'd0, 8'd9); step();
    drive_wr(1'b0, '0, '0);
    check("lw_pend", 32'(bus.pend[0]), 32'h1);
    step();
    check("lw_oldtick", 32'({bus.pend[0], bus.tick[0]}), 32'h3);
    step();
    for (int k = 0; k < 9; k++) begin
      check($sformatf("w9pend%0d", k), 32'(bus.pend[0]),    32'h0);
      check($sformatf("w9clk%0d", k),  32'(bus.clk_out[0]), 32'(k >= 5));
      check($sformatf("w9tick%0d", k), 32'(bus.tick[0]),    32'(k == 8));
      step();
    end

    // Write 0 stops the channel at the next wrap
    drive_wr(1'b1, 3'd0, 8'd0); step();
    drive_wr(1'b0, '0, '0);
    check("stop_pend", 32'(bus.pend[0]), 32'h1);
    repeat (7) step();
    check("stop_lasttick", 32'(bus.tick[0]), 32'h1);
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("stopped%0d", k), 32'({bus.pend[0], bus.clk_out[0], bus.tick[0]}), 32'h0);
    end

    // Sync: ch0=4, ch1=8 at unrelated phases, then re-phase
    drive_wr(1'b1, 3'd0, 8'd4); step();
    drive_wr(1'b0, '0, '0); step(); step();
    drive_wr(1'b1, 3'd1, 8'd8); step();
    drive_wr(1'b0, '0, '0); step();
    bus.sync = 1'b1; step(); bus.sync = 1'b0;
    for (int k = 0; k < 24; k++) begin
      check($sformatf("sy0tick%0d", k), 32'(bus.tick[0]),    32'((k % 4) == 3));
      check($sformatf("sy1tick%0d", k), 32'(bus.tick[1]),    32'((k % 8) == 7));
      check($sformatf("sy0clk%0d", k),  32'(bus.clk_out[0]), 32'((k % 4) >= 2));
      check($sformatf("sy1clk%0d", k),  32'(bus.clk_out[1]), 32'((k % 8) >= 4));
      check($sformatf("sypend%0d", k),  32'(bus.pend),       32'h0);
      step();
    end

    // Write in the same cycle as sync takes effect on that edge
    drive_wr(1'b1, 3'd1, 8'd6); bus.sync = 1'b1; step();
    drive_wr(1'b0, '0, '0); bus.sync = 1'b0;
    for (int k = 0; k < 12; k++) begin
      check($sformatf("ws0tick%0d", k), 32'(bus.tick[0]),    32'((k % 4) == 3));
      check($sformatf("ws1tick%0d", k), 32'(bus.tick[1]),    32'((k % 6) == 5));
      check($sformatf("ws1clk%0d", k),  32'(bus.clk_out[1]), 32'((k % 6) >= 3));
      step();
    end

    // Held sync pins every channel at cnt=0
    bus.sync = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("hold_tick%0d", k), 32'(bus.tick),    32'h0);
      check($sformatf("hold_clk%0d", k),  32'(bus.clk_out), 32'h0);
    end
    bus.sync = 1'b0;

    // P=1: tick stuck high, clk_out low
    drive_wr(1'b1, 3'd2, 8'd1); step();
    drive_wr(1'b0, '0, '0);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("p1tick%0d", k), 32'(bus.tick[2]),    32'h1);
      check($sformatf("p1clk%0d", k),  32'(bus.clk_out[2]), 32'h0);
      step();
    end

    // Write to channel 4 (nonexistent) during sync is ignored
    drive_wr(1'b1, 3'd4, 8'd1); bus.sync = 1'b1; step();
    drive_wr(1'b0, '0, '0); bus.sync = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("ig0tick%0d", k), 32'(bus.tick[0]),    32'((k % 4) == 3));
      check($sformatf("ig0clk%0d", k),  32'(bus.clk_out[0]), 32'((k % 4) >= 2));
      check($sformatf("ig1tick%0d", k), 32'(bus.tick[1]),    32'((k % 6) == 5));
      check($sformatf("ig2tick%0d", k), 32'(bus.tick[2]),    32'h1);
      check($sformatf("ig3tick%0d", k), 32'(bus.tick[3]),    32'h0);
      check($sformatf("igpend%0d", k),  32'(bus.pend),       32'h0);
      step();
    end

    // P=255: maximum period, tick every 255 cycles
    drive_wr(1'b1, 3'd3, 8'd255); step();
    drive_wr(1'b0, '0, '0);
    for (int k = 0; k < 510; k++) begin
      check($sformatf("p255tick%0d", k), 32'(bus.tick[3]),    32'((k % 255) == 254));
      check($sformatf("p255clk%0d", k),  32'(bus.clk_out[3]), 32'((k % 255) >= 128));
      step();
    end

    // Async reset with a staged value pending
    bus.sync = 1'b1; step(); bus.sync = 1'b0;
    drive_wr(1'b1, 3'd0, 8'd7); step();
    drive_wr(1'b0, '0, '0);
    check("rs_pend_before", 32'(bus.pend), 32'h1);
    check("rs_tick_before", 32'(bus.tick), 32'h4);
    #2 rst_n = 1'b0;
    #1;
    check("rs_async_clk",  32'(bus.clk_out), 32'h0);
    check("rs_async_tick", 32'(bus.tick),    32'h0);
    check("rs_async_pend", 32'(bus.pend),    32'h0);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      check($sformatf("rs_idle%0d", k), 32'({bus.pend, bus.clk_out, bus.tick}), 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
